alu_issue_sched: RTL and testbench

- Shares the single combinational ALU among NUM_REQ reservation-station requesters in the out-of-order core.
- Each cycle it round-robin selects one ready requester, registers its operands, opcode and tag into an issue stage, and drives the ALU from that stage.
- It captures the ALU result into a one-entry output buffer and presents it on the CDB with a valid/ready handshake.
- Sits between the RS issue logic and the CDB arbiter; instantiates the ALU as its only sub-module.

---
 rtl/alu_issue_sched_pkg.sv | 28 ++
 rtl/alu_issue_sched_alu.sv | 36 +++
 rtl/alu_issue_sched.sv | 137 +++++++++++++
 tb/tb_alu_issue_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_sched_pkg.sv
// ============================================================================
// Module  : alu_issue_sched_pkg
// Purpose : Shared ALU opcode encoding and widths for the ALU issue scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_issue_sched_pkg;

   localparam int OP_W      = 4;
   localparam int DEF_TAG_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_OR     = 4'd2,
      OP_XOR    = 4'd3,
      OP_LSHIFT = 4'd4,
      OP_RSHIFT = 4'd5,
      OP_LTHAN  = 4'd6,
      OP_LEQUAL = 4'd7,
      OP_RTHAN  = 4'd8,
      OP_REQUAL = 4'd9
   } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/alu_issue_sched_alu.sv
// ============================================================================
// Module  : alu_issue_sched_alu
// Purpose : Combinational 32-bit ALU; comparisons are unsigned, undefined ops give 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_sched_alu
   import alu_issue_sched_pkg::*;
(
   input  logic [OP_W-1:0] op_i,
   input  logic [31:0]     a_i,
   input  logic [31:0]     b_i,
   output logic [31:0]     res_o
);

   always_comb begin
      res_o = '0;
      case (op_i)
         OP_ADD:    res_o = a_i + b_i;
         OP_SUB:    res_o = a_i - b_i;
         OP_OR:     res_o = a_i | b_i;
         OP_XOR:    res_o = a_i ^ b_i;
         OP_LSHIFT: res_o = a_i << b_i[4:0];
         OP_RSHIFT: res_o = a_i >> b_i[4:0];
         OP_LTHAN:  res_o = {31'd0, (a_i <  b_i)};
         OP_LEQUAL: res_o = {31'd0, (a_i <= b_i)};
         OP_RTHAN:  res_o = {31'd0, (a_i >  b_i)};
         OP_REQUAL: res_o = {31'd0, (a_i >= b_i)};
         default:   res_o = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_issue_sched.sv
// ============================================================================
// Module  : alu_issue_sched
// Purpose : Round-robin issue of NUM_REQ requesters onto one ALU, result on CDB.
//           Optional perf counters enabled with `define ALU_SCHED_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_sched
   import alu_issue_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = DEF_TAG_W
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     flush_in,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*32-1:0]    req_op1,
   input  logic [NUM_REQ*32-1:0]    req_op2,
   input  logic [NUM_REQ*OP_W-1:0]  req_op,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic [NUM_REQ-1:0]       req_grant,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [31:0]              cdb_result,
   input  logic                     cdb_ready
`ifdef ALU_SCHED_PERF_EN
   ,
   output logic [31:0]              perf_stall_cnt,
   output logic [31:0]              perf_issue_cnt
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             issue_valid_q;
   logic [31:0]      op1_q, op2_q;
   logic [OP_W-1:0]  op_q;
   logic [TAG_W-1:0] tag_q;
   logic             cdb_valid_q;
   logic [TAG_W-1:0] cdb_tag_q;
   logic [31:0]      cdb_result_q;
   logic [31:0]      alu_res;

   logic             out_free, issue_adv, any_req, grant_en;
   logic [PTR_W-1:0] sel;

   // First valid requester at or after the pointer, wrapping.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [PTR_W-1:0]   p);
      logic             found;
      logic [PTR_W-1:0] pick;
      int               k;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = (int'(p) + i) % NUM_REQ;
         if (!found && v[k]) begin
            found = 1'b1;
            pick  = PTR_W'(k);
         end
      end
      return pick;
   endfunction

   assign out_free  = !cdb_valid_q || cdb_ready;
   assign issue_adv = rdy_in && out_free && !flush_in;
   assign any_req   = |req_valid;
   assign sel       = rr_pick(req_valid, ptr_q);
   // Gated by reset so the grant drops immediately on async reset assertion.
   assign grant_en  = issue_adv && any_req && rst_in;
   assign req_grant = grant_en ? (NUM_REQ'(1) << sel) : '0;
   assign ptr_d     = (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);

   alu_issue_sched_alu u_alu (
      .op_i  (op_q),
      .a_i   (op1_q),
      .b_i   (op2_q),
      .res_o (alu_res)
   );

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ptr_q         <= '0;
         issue_valid_q <= 1'b0;
         op1_q         <= '0;
         op2_q         <= '0;
         op_q          <= '0;
         tag_q         <= '0;
         cdb_valid_q   <= 1'b0;
         cdb_tag_q     <= '0;
         cdb_result_q  <= '0;
      end else if (flush_in) begin
         issue_valid_q <= 1'b0;
         cdb_valid_q   <= 1'b0;
      end else if (issue_adv) begin
         if (grant_en) ptr_q <= ptr_d;
         issue_valid_q <= any_req;
         op1_q         <= req_op1[32*int'(sel) +: 32];
         op2_q         <= req_op2[32*int'(sel) +: 32];
         op_q          <= req_op[OP_W*int'(sel) +: OP_W];
         tag_q         <= req_tag[TAG_W*int'(sel) +: TAG_W];
         cdb_valid_q   <= issue_valid_q;
         cdb_tag_q     <= tag_q;
         cdb_result_q  <= alu_res;
      end
   end

   assign cdb_valid  = cdb_valid_q;
   assign cdb_tag    = cdb_tag_q;
   assign cdb_result = cdb_result_q;

`ifdef ALU_SCHED_PERF_EN
   logic [31:0] stall_cnt_q, issue_cnt_q;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         stall_cnt_q <= '0;
         issue_cnt_q <= '0;
      end else begin
         if (rdy_in && any_req && !out_free && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (grant_en && (issue_cnt_q != '1))
            issue_cnt_q <= issue_cnt_q + 32'd1;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_issue_cnt = issue_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_sched.sv
// ============================================================================
// Module  : tb_alu_issue_sched
// Purpose : Directed self-checking bench for alu_issue_sched.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_sched;
   import alu_issue_sched_pkg::*;

   localparam int N  = 4;
   localparam int TW = 4;

   logic              clk_in, rst_in, rdy_in, flush_in, cdb_ready;
   logic [N-1:0]      req_valid;
   logic [N*32-1:0]   req_op1, req_op2;
   logic [N*4-1:0]    req_op;
   logic [N*TW-1:0]   req_tag;
   logic [N-1:0]      req_grant;
   logic              cdb_valid;
   logic [TW-1:0]     cdb_tag;
   logic [31:0]       cdb_result;
`ifdef ALU_SCHED_PERF_EN
   logic [31:0]       perf_stall_cnt, perf_issue_cnt;
`endif

   alu_issue_sched #(.NUM_REQ(N), .TAG_W(TW)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .flush_in  (flush_in),
      .req_valid (req_valid),
      .req_op1   (req_op1),
      .req_op2   (req_op2),
      .req_op    (req_op),
      .req_tag   (req_tag),
      .req_grant (req_grant),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_result(cdb_result),
      .cdb_ready (cdb_ready)
`ifdef ALU_SCHED_PERF_EN
      ,
      .perf_stall_cnt(perf_stall_cnt),
      .perf_issue_cnt(perf_issue_cnt)
`endif
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TW-1:0] tag);
      req_op1[32*i +: 32] = a;
      req_op2[32*i +: 32] = b;
      req_op[4*i +: 4]    = op;
      req_tag[TW*i +: TW] = tag;
   endtask

   typedef struct {
      logic [3:0]    op;
      logic [31:0]   a;
      logic [31:0]   b;
      logic [31:0]   exp;
      logic [TW-1:0] tag;
   } vec_t;

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{4'd0, 32'd5,          32'd7,  32'd12,         4'd3};
      vecs[1]  = '{4'd1, 32'd3,          32'd5,  32'hFFFF_FFFE,  4'd4};
      vecs[2]  = '{4'd4, 32'd1,          32'd33, 32'd2,          4'd5};
      vecs[3]  = '{4'd5, 32'h8000_0000,  32'd4,  32'h0800_0000,  4'd6};
      vecs[4]  = '{4'd2, 32'hF0F0_0000,  32'h0F, 32'hF0F0_000F,  4'd7};
      vecs[5]  = '{4'd3, 32'hFF00_FF00,  32'hFFFF_0000, 32'h00FF_FF00, 4'd8};
      vecs[6]  = '{4'd6, 32'd3,          32'd5,  32'd1,          4'd9};
      vecs[7]  = '{4'd7, 32'd5,          32'd5,  32'd1,          4'd10};
      vecs[8]  = '{4'd8, 32'd3,          32'd5,  32'd0,          4'd11};
      vecs[9]  = '{4'd9, 32'd7,          32'd7,  32'd1,          4'd12};
      vecs[10] = '{4'hF, 32'd9,          32'd9,  32'd0,          4'd13};
      vecs[11] = '{4'hA, 32'd1,          32'd2,  32'd0,          4'd14};

      rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; cdb_ready = 1'b1;
      req_valid = '0; req_op1 = '0; req_op2 = '0; req_op = '0; req_tag = '0;
      #1;
      chk("reset_cdb_valid",  {31'd0, cdb_valid}, 32'd0);
      chk("reset_grant",      {28'd0, req_grant}, 32'd0);
      chk("reset_cdb_tag",    {28'd0, cdb_tag},   32'd0);
      chk("reset_cdb_result", cdb_result,         32'd0);
      @(negedge clk_in); @(negedge clk_in);
      rst_in = 1'b1;

      // Opcode table through requester 0: grant now, result two edges later.
      for (int v = 0; v < 12; v++) begin
         @(negedge clk_in);
         set_req(0, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].tag);
         req_valid = 4'b0001;
         #1 chk($sformatf("op%0d_grant", v), {28'd0, req_grant}, 32'd1);
         @(negedge clk_in);
         req_valid = '0;
         @(negedge clk_in);
         chk($sformatf("op%0d_valid", v), {31'd0, cdb_valid}, 32'd1);
         chk($sformatf("op%0d_result", v), cdb_result, vecs[v].exp);
         chk($sformatf("op%0d_tag", v), {28'd0, cdb_tag}, {28'd0, vecs[v].tag});
      end

      // Async reset in the middle of a burst.
      for (int i = 0; i < N; i++) set_req(i, 4'd0, 32'(i), 32'd100, TW'(8 + i));
      @(negedge clk_in);
      req_valid = 4'b1111;
      @(negedge clk_in);
      @(posedge clk_in);
      #2;
      chk("burst_cdb_valid_pre", {31'd0, cdb_valid}, 32'd1);
      rst_in = 1'b0;
      #1;
      chk("async_rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
      chk("async_rst_grant",     {28'd0, req_grant}, 32'd0);
      @(negedge clk_in);
      req_valid = '0;
      rst_in = 1'b1;

      // Fairness: pointer restarts at 0, grants rotate, results back-to-back.
      for (int c = 0; c < 10; c++) begin
         @(negedge clk_in);
         if (c >= 2) begin
            chk($sformatf("fair%0d_valid", c), {31'd0, cdb_valid}, 32'd1);
            chk($sformatf("fair%0d_tag", c), {28'd0, cdb_tag}, 32'(8 + ((c - 2) % 4)));
            chk($sformatf("fair%0d_result", c), cdb_result, 32'(100 + ((c - 2) % 4)));
         end
         req_valid = (c < 8) ? 4'b1111 : 4'b0000;
         #1;
         if (c < 8) chk($sformatf("fair%0d_grant", c), {28'd0, req_grant}, 32'(1 << (c % 4)));
      end

      // Backpressure: pointer is 0 here.
      @(negedge clk_in);
      req_valid = 4'b0011;
      #1 chk("bp_grant0", {28'd0, req_grant}, 32'd1);
      @(negedge clk_in);
      req_valid = 4'b0010;
      #1 chk("bp_grant1", {28'd0, req_grant}, 32'd2);
      @(negedge clk_in);
      cdb_ready = 1'b0;
      req_valid = 4'b0100;
      #1 chk("bp_hold_grant_e2", {28'd0, req_grant}, 32'd0);
      for (int h = 0; h < 3; h++) begin
         @(negedge clk_in);
         #1;
         chk($sformatf("bp_hold%0d_valid", h), {31'd0, cdb_valid}, 32'd1);
         chk($sformatf("bp_hold%0d_tag", h), {28'd0, cdb_tag}, 32'd8);
         chk($sformatf("bp_hold%0d_result", h), cdb_result, 32'd100);
         if (h < 2) chk($sformatf("bp_hold%0d_grant", h), {28'd0, req_grant}, 32'd0);
      end
      cdb_ready = 1'b1;
      #1 chk("bp_release_grant", {28'd0, req_grant}, 32'd4);
      @(negedge clk_in);
      req_valid = '0;
      chk("bp_next_tag",    {28'd0, cdb_tag}, 32'd9);
      chk("bp_next_result", cdb_result,       32'd101);
      chk("bp_next_valid",  {31'd0, cdb_valid}, 32'd1);
      @(negedge clk_in);
      chk("bp_last_tag",    {28'd0, cdb_tag}, 32'd10);
      chk("bp_last_result", cdb_result,       32'd102);
      @(negedge clk_in);
      chk("bp_drained", {31'd0, cdb_valid}, 32'd0);

      // Flush: pointer is 3 here.
      req_valid = 4'b1111;
      #1 chk("fl_grant0", {28'd0, req_grant}, 32'd8);
      @(negedge clk_in);
      #1 chk("fl_grant1", {28'd0, req_grant}, 32'd1);
      @(negedge clk_in);
      chk("fl_pre_tag", {28'd0, cdb_tag}, 32'd11);
      flush_in = 1'b1;
      #1 chk("fl_no_grant", {28'd0, req_grant}, 32'd0);
      @(negedge clk_in);
      flush_in = 1'b0;
      chk("fl_cdb_cleared", {31'd0, cdb_valid}, 32'd0);
      #1 chk("fl_ptr_kept", {28'd0, req_grant}, 32'd2);
      @(negedge clk_in);
      req_valid = '0;
      chk("fl_no_broadcast", {31'd0, cdb_valid}, 32'd0);
      @(negedge clk_in);
      chk("fl_after_valid", {31'd0, cdb_valid}, 32'd1);
      chk("fl_after_tag",   {28'd0, cdb_tag}, 32'd9);

      // rdy_in low freezes and blocks grants.
      @(negedge clk_in);
      rdy_in = 1'b0;
      req_valid = 4'b1111;
      #1 chk("rdy_low_grant", {28'd0, req_grant}, 32'd0);
      @(negedge clk_in);
      rdy_in = 1'b1;
      #1 chk("rdy_back_grant", {28'd0, req_grant}, 32'd4);
      @(negedge clk_in);
      req_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
